// File: rtl/sdpram_stream_pkg.sv
// Shared definitions for the SDPRAM read-side streamer: FSM encodings, skid depth,
// and an elaboration-time guard on the RAM read latency.
// No ports; imported by sdpram_rd_skid and sdpram_rd_streamer.
`ifndef SDPRAM_STREAM_PKG_SV
`define SDPRAM_STREAM_PKG_SV

// Only a 1-cycle RAM read latency is supported; anything else stops elaboration.
`define SDPRAM_CHECK_RD_LATENCY(lat) \
    if ((lat) != 1) begin : g_bad_rd_latency \
        $error("sdpram_rd_streamer: RAM_RD_LATENCY must be 1"); \
    end

package sdpram_stream_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Two entries cover the one word in flight plus one word stalled at the output.
    localparam int SKID_DEPTH = 2;

endpackage

`endif

// File: rtl/sdpram_rd_skid.sv
// 2-entry FIFO of {last, data}; head outputs are registers.
// Latency: a pushed word appears at the head the cycle after the push when the FIFO was empty.
// Backpressure: no ready; the producer must never push into a full FIFO (count==2 without pop).
// Ports: clk/rst (sync, active-high), push/push_data/push_last, pop,
//        head_valid/head_data/head_last, count[1:0].
module sdpram_rd_skid
    import sdpram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [1:0]            count
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] tail_data;
    logic                  tail_last;

    assign head_valid = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Head keeps its old contents when the FIFO empties; m_valid masks it.
                    if (count == FULL) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == FULL) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end else begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sdpram_rd_streamer.sv
// Burst read sequencer for a 1-cycle-latency SDPRAM read port, emitting a valid/ready stream.
// Latency: cmd handshake cycle 0 -> address cycle 1 -> data cycle 2 -> m_valid cycle 3; 1 beat/cycle.
// Backpressure: m_ready low stalls output; issuing stops once buffered + in-flight words reach 2.
// Ports: rd_clk/rd_rst (sync, active-high), cmd_valid/cmd_ready/cmd_addr/cmd_len,
//        ram_rd_addr/ram_rd_data, m_valid/m_ready/m_data/m_last, busy, done.
module sdpram_rd_streamer
    import sdpram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    `SDPRAM_CHECK_RD_LATENCY(RAM_RD_LATENCY)

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            buf_count;
    logic                  pop;
    logic                  issue;
    logic                  drain_exit;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign pop       = m_valid & m_ready;

    // The pointer register drives the RAM directly: it is loaded at the handshake, so the
    // first address is on the RAM in cycle 1 and advances only when that address is issued.
    assign ram_rd_addr = addr_ptr;

    // Occupancy after this cycle's pop must leave room for the word this issue returns.
    assign issue = (state == RUN) &&
                   (({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    // Everything of the burst sits in the buffer or in flight, and the tagged last word is
    // the final one, so an empty pipe after this cycle's pop means the last beat was taken.
    assign drain_exit = (state == DRAIN) && !inflight &&
                        ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state         <= IDLE;
            addr_ptr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= drain_exit;
            inflight      <= issue;
            inflight_last <= issue && (remaining == '0);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_ptr  <= cmd_addr;
                        remaining <= cmd_len;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_ptr  <= addr_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset clears inflight, so RAM data returning for an abandoned burst is never captured.
    sdpram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (rd_clk),
        .rst        (rd_rst),
        .push       (inflight),
        .push_data  (ram_rd_data),
        .push_last  (inflight_last),
        .pop        (pop),
        .head_valid (m_valid),
        .head_data  (m_data),
        .head_last  (m_last),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_sdpram_rd_streamer.sv
module tb_sdpram_rd_streamer;

    logic        clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic [7:0]  ram_rd_addr;
    logic [31:0] ram_rd_data = 32'h0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    sdpram_rd_streamer #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .RAM_RD_LATENCY (1)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // RAM contents mem[k] = 0xA5000000 + k, read with one cycle of latency.
    function automatic logic [31:0] mem_word(input int k);
        return 32'hA5000000 + 32'(k % 256);
    endfunction

    always @(posedge clk) ram_rd_data <= mem_word(int'(ram_rd_addr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + logs ----------------
    typedef struct { logic [31:0] dat; logic last; } exp_t;
    typedef struct { int cyc; logic [31:0] dat; logic last; } beat_t;

    exp_t  exp_q[$];
    beat_t beat_log[$];
    int    hs_log[$];
    int    done_log[$];
    logic [7:0] addr_hist [0:4095];
    logic       busy_hist [0:4095];

    logic        exp_done = 1'b0;
    logic        post_rst = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] held_dat = 32'h0;
    logic        held_last = 1'b0;

    always @(negedge clk) begin
        if (rd_rst) begin
            exp_q.delete();
            exp_done = 1'b0;
            post_rst = 1'b1;
            stalled  = 1'b0;
        end else begin
            if (post_rst) begin
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_ram_rd_addr", ram_rd_addr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                post_rst = 1'b0;
            end
            chk("done_pulse", done, exp_done);
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            chk("skid_no_overflow", dut.u_skid.count <= 2'd2, 1);
            if (stalled) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held_dat);
                chk("hold_last", m_last, held_last);
            end
            exp_done = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_data, 0);
                    chk("unexpected_beat_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.dat);
                    chk("beat_last", m_last, e.last);
                    exp_done = e.last;
                end
                beat_log.push_back('{cyc, m_data, m_last});
            end
            stalled   = m_valid && !m_ready;
            held_dat  = m_data;
            held_last = m_last;
            if (done) done_log.push_back(cyc);
            if (cmd_valid && cmd_ready) begin
                for (int i = 0; i <= int'(cmd_len); i++)
                    exp_q.push_back('{mem_word(int'(cmd_addr) + i), i == int'(cmd_len)});
                hs_log.push_back(cyc);
            end
            if (cyc < 4096) begin
                addr_hist[cyc] = ram_rd_addr;
                busy_hist[cyc] = busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        beat_log.delete();
        hs_log.delete();
        done_log.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        @(negedge clk); #1;
        while (!cmd_ready && k < 300) begin @(negedge clk); #1; k++; end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        // Post-handshake field changes must be ignored.
        cmd_valid = 1'b0; cmd_addr = 8'h77; cmd_len = 8'hFF;
    endtask

    task automatic wait_done_n(input int n, input int budget);
        int k = 0;
        while (done_log.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk("wait_done", done_log.size() >= n, 1);
    endtask

    task automatic chk_beat(input string name, input int idx, input int rel_cyc,
                            input logic [31:0] dat, input logic last);
        if (beat_log.size() > idx && hs_log.size() > 0) begin
            chk({name, "_cyc"}, 64'(beat_log[idx].cyc - hs_log[0]), 64'(rel_cyc));
            chk({name, "_dat"}, beat_log[idx].dat, dat);
            chk({name, "_last"}, beat_log[idx].last, last);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    logic [3:0] rdy_pat = 4'b1001;   // m_ready sequence 1,0,0,1 (bit i%4)

    initial begin
        int hs0;
        int k;
        repeat (3) @(posedge clk);
        #1 rd_rst = 1'b0;
        repeat (2) @(posedge clk);

        // T1: single word at 0x10.
        clear_logs();
        send_cmd(8'h10, 8'd0);
        wait_done_n(1, 50);
        chk("t1_beats", beat_log.size(), 1);
        chk_beat("t1_b0", 0, 3, 32'hA5000010, 1'b1);
        if (done_log.size() > 0 && hs_log.size() > 0)
            chk("t1_done_cyc", 64'(done_log[0] - hs_log[0]), 4);

        // T2: 4 words at 0x20, continuous ready.
        @(posedge clk);
        clear_logs();
        send_cmd(8'h20, 8'd3);
        wait_done_n(1, 50);
        chk("t2_beats", beat_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_beat("t2_b", i, 3 + i, 32'hA5000020 + 32'(i), i == 3);
        if (done_log.size() > 0 && hs_log.size() > 0) begin
            hs0 = hs_log[0];
            chk("t2_done_cyc", 64'(done_log[0] - hs0), 7);
            chk("t2_busy_c0", busy_hist[hs0], 0);
            for (int c = 1; c <= 6; c++) chk("t2_busy_run", busy_hist[hs0 + c], 1);
            chk("t2_busy_c7", busy_hist[hs0 + 7], 0);
        end

        // T3: same burst with m_ready toggling 1,0,0,1.
        @(posedge clk); #1;
        clear_logs();
        cmd_valid = 1'b1; cmd_addr = 8'h20; cmd_len = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 8'h77;
        k = 0;
        while (done_log.size() == 0 && k < 80) begin
            m_ready = rdy_pat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        m_ready = 1'b1;
        chk("t3_done", done_log.size(), 1);
        chk("t3_beats", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_dat", beat_log[i].dat, 32'hA5000020 + 32'(i));
                chk("t3_last", beat_log[i].last, i == 3);
            end
            chk("t3_stalled", (beat_log[3].cyc - beat_log[0].cyc) > 3, 1);
        end

        // T4: address wrap 0xFE -> 0xFF -> 0x00.
        @(posedge clk);
        clear_logs();
        send_cmd(8'hFE, 8'd2);
        wait_done_n(1, 50);
        if (hs_log.size() > 0) begin
            hs0 = hs_log[0];
            chk("t4_addr1", addr_hist[hs0 + 1], 8'hFE);
            chk("t4_addr2", addr_hist[hs0 + 2], 8'hFF);
            chk("t4_addr3", addr_hist[hs0 + 3], 8'h00);
        end
        chk_beat("t4_b0", 0, 3, 32'hA50000FE, 1'b0);
        chk_beat("t4_b1", 1, 4, 32'hA50000FF, 1'b0);
        chk_beat("t4_b2", 2, 5, 32'hA5000000, 1'b1);

        // T5: 256-word burst abandoned by reset after beat 100, then a fresh burst.
        @(posedge clk);
        clear_logs();
        send_cmd(8'h00, 8'd255);
        k = 0;
        while (beat_log.size() < 100 && k < 400) begin @(negedge clk); #1; k++; end
        chk("t5_reached_100", beat_log.size() >= 100, 1);
        @(posedge clk); #1 rd_rst = 1'b1;
        @(posedge clk); #1 rd_rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", done_log.size(), 0);
        chk("t5_idle_ready", cmd_ready, 1);
        clear_logs();
        send_cmd(8'h05, 8'd1);
        wait_done_n(1, 50);
        repeat (4) @(posedge clk);
        chk("t5_beats", beat_log.size(), 2);
        chk_beat("t5_b0", 0, 3, 32'hA5000005, 1'b0);
        chk_beat("t5_b1", 1, 4, 32'hA5000006, 1'b1);

        // T6: back-to-back commands with cmd_valid held high.
        clear_logs();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 8'h40; cmd_len = 8'd1;
        @(posedge clk); #1;
        cmd_addr = 8'h80;
        k = 0;
        @(negedge clk); #1;
        while (!cmd_ready && k < 50) begin @(negedge clk); #1; k++; end
        chk("t6_second_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 8'h77;
        wait_done_n(2, 50);
        chk("t6_hs_count", hs_log.size(), 2);
        if (hs_log.size() == 2 && done_log.size() >= 1)
            chk("t6_accept_in_done_cycle", 64'(hs_log[1]), 64'(done_log[0]));
        chk_beat("t6_b0", 0, 3, 32'hA5000040, 1'b0);
        chk_beat("t6_b1", 1, 4, 32'hA5000041, 1'b1);
        chk_beat("t6_b2", 2, 8, 32'hA5000080, 1'b0);
        chk_beat("t6_b3", 3, 9, 32'hA5000081, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("model_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
